// File: rtl/dram_pkg.sv
// dram_pkg: shared constants, state encoding and address-range helper for
// the DRAM front-end controller (dram_ctrl and dram_init_seq).
package dram_pkg;

  localparam int unsigned WORD_DEPTH = 70;  // physical data-RAM words
  localparam int unsigned MAX_WAIT   = 4;   // ext denials before a forced grant
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;

  // ST_XGNT is never stored: it is the current-cycle view of IDLE while the
  // expansion port owns the RAM.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_XGNT = 2'd2
  } state_t;

  // True when an address maps onto a physical RAM word.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a,
                                   input int unsigned       depth);
    return (32'(a) < depth);
  endfunction

endpackage

// File: rtl/dram_init_seq.sv
// dram_init_seq: post-reset clear sequencer. Steps a clear address from 0 up
// to WORD_DEPTH-1, one word per cycle, then raises a sticky done flag.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (restarts the sequence at 0)
//   o_addr   current clear address
//   o_last   current clear address is the final word
//   o_done   clear sequence complete (registered, sticky until reset)
module dram_init_seq #(
  parameter int unsigned WORD_DEPTH = dram_pkg::WORD_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  output logic [dram_pkg::ADDR_W-1:0] o_addr,
  output logic                       o_last,
  output logic                       o_done
);
  import dram_pkg::*;

  logic [ADDR_W-1:0] r_addr;
  logic              r_done;

  assign o_addr = r_addr;
  assign o_last = (r_addr == ADDR_W'(WORD_DEPTH - 1));
  assign o_done = r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
      r_done <= 1'b0;
    end else if (!r_done) begin
      if (o_last) r_done <= 1'b1;
      else        r_addr <= r_addr + 1'b1;
    end
  end

endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: single-port data-RAM arbiter between a CPU port (priority) and
// an expansion (ext) request/ack port, with a post-reset RAM clear.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cpu_en/addr/we/din           CPU access this cycle
//   cpu_dout                     CPU read data, combinational from ram_dout
//   cpu_stall                    CPU access not performed this cycle
//   ext_req/we/addr/din          ext request, held until ext_ack
//   ext_ack, ext_dout            registered one-cycle completion + read data
//   ram_addr/we/din, ram_dout    data-RAM interface (sync write, async read)
//   init_done                    RAM clear complete
module dram_ctrl #(
  parameter int unsigned WORD_DEPTH = dram_pkg::WORD_DEPTH,
  parameter int unsigned MAX_WAIT   = dram_pkg::MAX_WAIT
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cpu_en,
  input  logic [dram_pkg::ADDR_W-1:0] cpu_addr,
  input  logic                        cpu_we,
  input  logic [dram_pkg::DATA_W-1:0] cpu_din,
  output logic [dram_pkg::DATA_W-1:0] cpu_dout,
  output logic                        cpu_stall,
  input  logic                        ext_req,
  input  logic                        ext_we,
  input  logic [dram_pkg::ADDR_W-1:0] ext_addr,
  input  logic [dram_pkg::DATA_W-1:0] ext_din,
  output logic                        ext_ack,
  output logic [dram_pkg::DATA_W-1:0] ext_dout,
  output logic [dram_pkg::ADDR_W-1:0] ram_addr,
  output logic                        ram_we,
  output logic [dram_pkg::DATA_W-1:0] ram_din,
  input  logic [dram_pkg::DATA_W-1:0] ram_dout,
  output logic                        init_done
);
  import dram_pkg::*;

  localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  state_t            r_state;
  logic              r_ack;
  logic [DATA_W-1:0] r_ext_dout;
  logic [WAIT_W-1:0] r_wait;

  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_clr_last;
  logic              w_done;
  logic              w_idle;
  logic              w_ext_ok;
  logic              w_force;
  logic              w_grant;
  state_t            w_cur_state;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_ram_din;

  dram_init_seq #(.WORD_DEPTH(WORD_DEPTH)) u_init_seq (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .o_addr  (w_clr_addr),
    .o_last  (w_clr_last),
    .o_done  (w_done)
  );

  // Ext is eligible only in IDLE and never in the cycle its previous ack is
  // showing, which caps ext throughput at one access per two cycles.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_ext_ok    = w_idle && ext_req && !r_ack;
  assign w_force     = w_ext_ok && (r_wait == WAIT_W'(MAX_WAIT));
  assign w_grant     = w_ext_ok && (!cpu_en || w_force);
  assign w_cur_state = w_grant ? ST_XGNT : r_state;

  always_comb begin
    w_ram_addr = cpu_addr;
    w_ram_din  = cpu_din;
    w_ram_we   = 1'b0;
    case (w_cur_state)
      ST_INIT: begin
        w_ram_addr = w_clr_addr;
        w_ram_din  = '0;
        w_ram_we   = 1'b1;
      end
      ST_XGNT: begin
        w_ram_addr = ext_addr;
        w_ram_din  = ext_din;
        w_ram_we   = ext_we && addr_ok(ext_addr, WORD_DEPTH);
      end
      default: begin
        w_ram_we   = cpu_en && cpu_we && addr_ok(cpu_addr, WORD_DEPTH);
      end
    endcase
  end

  assign ram_addr  = w_ram_addr;
  assign ram_we    = w_ram_we;
  assign ram_din   = w_ram_din;
  assign cpu_dout  = addr_ok(cpu_addr, WORD_DEPTH) ? ram_dout : '0;
  assign cpu_stall = (r_state == ST_INIT) || w_force;
  assign ext_ack   = r_ack;
  assign ext_dout  = r_ext_dout;
  assign init_done = w_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_INIT;
      r_ack      <= 1'b0;
      r_ext_dout <= '0;
      r_wait     <= '0;
    end else begin
      case (r_state)
        ST_INIT: if (w_clr_last) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      r_ack <= w_grant;
      if (w_grant)
        r_ext_dout <= addr_ok(ext_addr, WORD_DEPTH) ? ram_dout : '0;

      // Counts only denials caused by the CPU; never passes MAX_WAIT because
      // reaching it forces a grant, which clears it.
      if (w_grant || !ext_req)
        r_wait <= '0;
      else if (w_ext_ok)
        r_wait <= r_wait + 1'b1;
    end
  end

endmodule
